// File: rtl/demux_buf.sv
// demux_buf: 1-to-8 demultiplexer with a one-word skid buffer per output lane.
// Define DEMUX_ACCEPT_CNT_EN to build the 16-bit accepted-word counter.
module demux_buf #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         chosen,
   input  logic [WIDTH-1:0]   line_in,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [8*WIDTH-1:0] out_data,
   output logic [7:0]         out_valid,
   input  logic [7:0]         out_ready,
   output logic [15:0]        accept_cnt
);

   logic accept;

   // Only the addressed lane decides readiness: free now, or emptying on this edge.
   assign in_ready = ~out_valid[chosen] | out_ready[chosen];
   assign accept   = in_valid & in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         logic             load;
         logic             valid_reg;
         logic [WIDTH-1:0] data_reg;

         assign load = accept && (chosen == 3'(gi));

         // A reload wins over a drain so a same-cycle drain/load keeps the lane full.
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg <= 1'b0;
               data_reg  <= '0;
            end else if (load) begin
               valid_reg <= 1'b1;
               data_reg  <= line_in;
            end else if (out_ready[gi]) begin
               valid_reg <= 1'b0;
            end
         end

         assign out_valid[gi]                  = valid_reg;
         assign out_data[gi*WIDTH +: WIDTH]    = data_reg;
      end
   endgenerate

`ifdef DEMUX_ACCEPT_CNT_EN
   logic [15:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= 16'h0000;
      end else if (accept) begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign accept_cnt = cnt_reg;
`else
   assign accept_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_demux_buf.sv
// tb_demux_buf: randomized and directed stimulus for demux_buf with per-lane
// expected-word queues popped by an independent delivery monitor.
module tb_demux_buf;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [2:0]     chosen;
   logic [W-1:0]   line_in;
   logic           in_valid;
   logic           in_ready;
   logic [8*W-1:0] out_data;
   logic [7:0]     out_valid;
   logic [7:0]     out_ready;
   logic [15:0]    accept_cnt;

   demux_buf #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .chosen(chosen), .line_in(line_in),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .accept_cnt(accept_cnt)
   );

   always #5 clk = ~clk;

   typedef logic [W-1:0] word_q_t[$];
   word_q_t      lane_q [8];     // words accepted but not yet delivered
   logic [W-1:0] last_val [8];   // last word written into each lane
   logic [15:0]  model_cnt;
   logic         rst_pend;
   int           n_cmp = 0;
   int           n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_cnt();
`ifdef DEMUX_ACCEPT_CNT_EN
      return model_cnt;
`else
      return 16'h0000;
`endif
   endfunction

   // One clock of stimulus: drive just after the edge, check state, then update the model.
   task automatic cycle(input logic r, input logic iv, input logic [2:0] ch,
                        input logic [W-1:0] d, input logic [7:0] ordy);
      logic [7:0] ev;
      logic       er;
      @(posedge clk);
      #1;
      if (rst_pend) begin
         for (int k = 0; k < 8; k++) begin
            lane_q[k].delete();
            last_val[k] = '0;
         end
         model_cnt = 16'h0000;
      end
      rst = r; in_valid = iv; chosen = ch; line_in = d; out_ready = ordy;
      rst_pend = r;
      #1;
      for (int k = 0; k < 8; k++) ev[k] = (lane_q[k].size() != 0);
      er = (lane_q[ch].size() == 0) || ordy[ch];
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("accept_cnt", 64'(accept_cnt), 64'(exp_cnt()));
      for (int k = 0; k < 8; k++)
         chk($sformatf("lane%0d_data", k), 64'(out_data[k*W +: W]), 64'(last_val[k]));
      if (!r && iv && er) begin
         lane_q[ch].push_back(d);
         last_val[ch] = d;
         model_cnt = model_cnt + 16'd1;
      end
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 3'd0, '0, 8'h00);
   endtask

   // Delivery monitor: a lane delivers on the edge after it shows valid & ready.
   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            for (int k = 0; k < 8; k++) begin
               if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
                  if (lane_q[k].size() == 0) begin
                     chk($sformatf("unexpected_word_lane%0d", k), 64'(out_data[k*W +: W]), 64'hFFFF_FFFF_FFFF_FFFF);
                  end else begin
                     chk($sformatf("drain_lane%0d", k), 64'(out_data[k*W +: W]), 64'(lane_q[k].pop_front()));
                  end
               end
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 8; k++) last_val[k] = '0;
      model_cnt = 16'h0000;
      rst = 1'b1; in_valid = 1'b0; chosen = 3'd0; line_in = '0; out_ready = 8'h00;
      rst_pend = 1'b1;
      @(posedge clk);
      // In reset with a word offered: ready is 1 but nothing may be accepted.
      cycle(1'b1, 1'b1, 3'd6, 32'h5555_AAAA, 8'h00);
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      // Single transfer
      cycle(1'b0, 1'b1, 3'd3, 32'hDEADBEEF, 8'h00);
      idle();
      chk("single_valid", 64'(out_valid), 64'h08);
      chk("single_data", 64'(out_data[3*W +: W]), 64'hDEADBEEF);

      // Backpressure on a full lane, then a free lane
      cycle(1'b0, 1'b1, 3'd3, 32'h1234, 8'h00);
      chk("bp_ready_full", 64'(in_ready), 64'd0);
      cycle(1'b0, 1'b1, 3'd5, 32'h5555, 8'h00);
      chk("bp_ready_free", 64'(in_ready), 64'd1);
      idle();
      chk("bp_valid", 64'(out_valid), 64'h28);
      chk("bp_data3", 64'(out_data[3*W +: W]), 64'hDEADBEEF);

      // Simultaneous drain and load of lane 3
      cycle(1'b0, 1'b1, 3'd3, 32'hCAFE, 8'h08);
      chk("dl_ready", 64'(in_ready), 64'd1);
      idle();
      chk("dl_valid3", 64'(out_valid[3]), 64'd1);
      chk("dl_data3", 64'(out_data[3*W +: W]), 64'hCAFE);

      // Sweep: fill all lanes, then drain all at once
      cycle(1'b1, 1'b0, 3'd0, '0, 8'h00);
      for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 3'(k), W'(k + 1), 8'h00);
      idle();
      chk("sweep_full", 64'(out_valid), 64'hFF);
      cycle(1'b0, 1'b0, 3'd0, '0, 8'hFF);
      idle();
      chk("sweep_empty", 64'(out_valid), 64'h00);
      for (int k = 0; k < 8; k++)
         chk("sweep_data", 64'(out_data[k*W +: W]), 64'(k + 1));

      // Reset with every lane full: buffered words are discarded
      for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 3'(k), $urandom(), 8'h00);
      cycle(1'b1, 1'b0, 3'd0, '0, 8'hFF);
      idle();
      chk("midrst_valid", 64'(out_valid), 64'h00);
      chk("midrst_data", 64'(out_data == '0), 64'd1);
      chk("midrst_cnt", 64'(accept_cnt), 64'd0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
               3'($urandom_range(0, 7)), $urandom(), 8'($urandom()));
      end

      // Counter wrap: exactly 65536 accepts after a reset
      cycle(1'b1, 1'b0, 3'd0, '0, 8'h00);
      for (int i = 0; i < 65536; i++)
         cycle(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom(), 8'hFF);
      cycle(1'b0, 1'b0, 3'd0, '0, 8'hFF);
      chk("cnt_wrap", 64'(accept_cnt), 64'h0000);

      idle();
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
